// File: rtl/dsp_common_pkg.sv
// Shared defaults and types for the chunk processing chain
// (collector, processor and output drain).
package dsp_common_pkg;

  localparam int SAMPLE_SIZE  = 24;
  localparam int IO_BUFF_SIZE = 64;

  typedef logic [SAMPLE_SIZE-1:0] sample_t;

endpackage : dsp_common_pkg

// File: rtl/pingpong_sample_ram.sv
// Two-bank sample store with one synchronous write port and one
// asynchronous read port. Contents are never reset.
module pingpong_sample_ram
  import dsp_common_pkg::*;
#(
  parameter int DATA_W = SAMPLE_SIZE,
  parameter int DEPTH  = IO_BUFF_SIZE,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [0:2*DEPTH-1];

  // Write port; bank bit is the address MSB.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem_q[{rd_bank, rd_addr}];

endmodule : pingpong_sample_ram

// File: rtl/chunk_collector.sv
// Collects incoming samples into a ping-pong buffer, pulses on each completed
// chunk and serves the consumer's read port from the last completed bank.
module chunk_collector
  import dsp_common_pkg::*;
#(
  parameter int SAMPLE_SIZE      = dsp_common_pkg::SAMPLE_SIZE,
  parameter int IO_BUFF_SIZE     = dsp_common_pkg::IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic [SAMPLE_SIZE-1:0]      sample_data,
  input  logic                        chunk_release,
  input  logic                        overrun_clear,
  input  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
  output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
  output logic                        chunk_pulse,
  output logic [IO_BUFF_PTR_BITS-1:0] fill_level,
  output logic                        overrun
);

  localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  logic [IO_BUFF_PTR_BITS-1:0] write_ptr_q, write_ptr_d;
  logic                        write_bank_q, write_bank_d;
  logic                        pending_q, pending_d;
  logic                        overrun_q, overrun_d;
  logic                        chunk_pulse_q, chunk_pulse_d;
  logic                        write_fire_s;
  logic                        complete_s;

  assign write_fire_s = enable & sample_valid;

  // Pointer/bank advance and flag update for the next cycle.
  always_comb begin
    write_ptr_d   = write_ptr_q;
    write_bank_d  = write_bank_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    complete_s    = 1'b0;

    if (!enable) begin
      // Partial chunk is dropped; release and clear wait until re-enabled.
      write_ptr_d = {IO_BUFF_PTR_BITS{1'b0}};
    end else begin
      if (sample_valid) begin
        if (write_ptr_q == PTR_LAST) begin
          write_ptr_d  = {IO_BUFF_PTR_BITS{1'b0}};
          write_bank_d = ~write_bank_q;
          complete_s   = 1'b1;
        end else begin
          write_ptr_d = write_ptr_q + {{(IO_BUFF_PTR_BITS-1){1'b0}}, 1'b1};
        end
      end else begin
        write_ptr_d = write_ptr_q;
      end

      // A completion always leaves a chunk pending, even alongside a release.
      if (complete_s) begin
        pending_d = 1'b1;
      end else if (chunk_release) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end

      if (complete_s && pending_q && !chunk_release) begin
        overrun_d = 1'b1;
      end else if (overrun_clear) begin
        overrun_d = 1'b0;
      end else begin
        overrun_d = overrun_q;
      end
    end

    chunk_pulse_d = complete_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ptr_q   <= {IO_BUFF_PTR_BITS{1'b0}};
      write_bank_q  <= 1'b0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      chunk_pulse_q <= 1'b0;
    end else begin
      write_ptr_q   <= write_ptr_d;
      write_bank_q  <= write_bank_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      chunk_pulse_q <= chunk_pulse_d;
    end
  end

  pingpong_sample_ram #(
    .DATA_W (SAMPLE_SIZE),
    .DEPTH  (IO_BUFF_SIZE),
    .ADDR_W (IO_BUFF_PTR_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (write_fire_s),
    .wr_bank (write_bank_q),
    .wr_addr (write_ptr_q),
    .wr_data (sample_data),
    .rd_bank (~write_bank_q),
    .rd_addr (input_buff_ptr),
    .rd_data (input_buff_sample)
  );

  assign chunk_pulse = chunk_pulse_q;
  assign fill_level  = write_ptr_q;
  assign overrun     = overrun_q;

endmodule : chunk_collector

// File: tb/tb_chunk_collector.sv
// Directed bench for chunk_collector with a scoreboard: each expected chunk
// completion is queued with its expected overrun flag and checked on chunk_pulse.
module tb_chunk_collector;

  localparam int SW = 24;
  localparam int NB = 4;
  localparam int PB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          chunk_release = 1'b0;
  logic          overrun_clear = 1'b0;
  logic [PB-1:0] input_buff_ptr = '0;
  logic [SW-1:0] input_buff_sample;
  logic          chunk_pulse;
  logic [PB-1:0] fill_level;
  logic          overrun;

  int total = 0;
  int bad = 0;
  logic exp_q[$];

  chunk_collector #(.SAMPLE_SIZE(SW), .IO_BUFF_SIZE(NB), .IO_BUFF_PTR_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .chunk_release(chunk_release),
    .overrun_clear(overrun_clear), .input_buff_ptr(input_buff_ptr),
    .input_buff_sample(input_buff_sample), .chunk_pulse(chunk_pulse),
    .fill_level(fill_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe four consecutive samples; optionally release on the final one.
  task automatic send_chunk(input logic [SW-1:0] base, input logic rel_last, input logic exp_ov);
    exp_q.push_back(exp_ov);
    for (int i = 0; i < NB; i++) begin
      sample_valid  = 1'b1;
      sample_data   = base + SW'(i);
      chunk_release = rel_last && (i == NB - 1);
      step();
    end
    sample_valid  = 1'b0;
    chunk_release = 1'b0;
    chk("pulse_after_last", chunk_pulse, 1'b1);
    chk("fill_wrap", fill_level, 2'd0);
  endtask

  task automatic read_chunk(input logic [SW-1:0] base);
    for (int i = 0; i < NB; i++) begin
      input_buff_ptr = PB'(i);
      #1;
      chk($sformatf("read_%0h_p%0d", base, i), input_buff_sample, base + SW'(i));
    end
  endtask

  task automatic release_pulse();
    chunk_release = 1'b1;
    step();
    chunk_release = 1'b0;
  endtask

  // Monitor: every chunk_pulse must match the next queued completion.
  initial begin
    forever begin
      @(negedge clk);
      if (chunk_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          logic ov;
          ov = exp_q.pop_front();
          chk("sb_overrun", overrun, ov);
          chk("sb_fill", fill_level, 2'd0);
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_pulse", chunk_pulse, 1'b0);
    chk("rst_fill", fill_level, 2'd0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    // Fill one chunk
    send_chunk(24'h000001, 1'b0, 1'b0);
    read_chunk(24'h000001);
    step();
    chk("pulse_one_cycle", chunk_pulse, 1'b0);

    // Ping-pong with release between chunks
    release_pulse();
    send_chunk(24'h00000A, 1'b0, 1'b0);
    read_chunk(24'h00000A);
    chk("pingpong_overrun", overrun, 1'b0);

    // Overrun: two chunks without release
    release_pulse();
    send_chunk(24'h000100, 1'b0, 1'b0);
    send_chunk(24'h000200, 1'b0, 1'b1);
    read_chunk(24'h000200);
    step();
    step();
    chk("overrun_held", overrun, 1'b1);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    chk("overrun_cleared", overrun, 1'b0);

    // Release coincides with completion: no overrun, still pending
    send_chunk(24'h000600, 1'b1, 1'b0);
    chk("collision_no_overrun", overrun, 1'b0);
    send_chunk(24'h000700, 1'b0, 1'b1);
    chk("collision_pending_kept", overrun, 1'b1);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    release_pulse();
    chk("clear_again", overrun, 1'b0);

    // Enable drop mid-chunk
    sample_valid = 1'b1;
    sample_data = 24'h000300;
    step();
    sample_data = 24'h000301;
    step();
    sample_valid = 1'b0;
    chk("fill_two", fill_level, 2'd2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data = 24'h0003F0 + SW'(i);
      step();
      chk("fill_disabled", fill_level, 2'd0);
    end
    sample_valid = 1'b0;
    enable = 1'b1;
    send_chunk(24'h000310, 1'b0, 1'b0);
    read_chunk(24'h000310);

    // Async reset mid-chunk
    release_pulse();
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data = 24'h000400 + SW'(i);
      step();
    end
    sample_valid = 1'b0;
    chk("fill_three", fill_level, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fill", fill_level, 2'd0);
    chk("arst_pulse", chunk_pulse, 1'b0);
    chk("arst_overrun", overrun, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_fill", fill_level, 2'd0);
    send_chunk(24'h000500, 1'b0, 1'b0);
    read_chunk(24'h000500);
    step();
    step();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_chunk_collector
